// File: rtl/mul_issue_ctrl.sv
// Valid/ready front-end for the signed 32x32 multiplier. It launches the
// multiplier, waits for done, and holds a post-processed 32-bit result.
module mul_issue_ctrl #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_start,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      mul_product,
  input  logic             mul_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_ovf,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0]  OP_MUL    = 2'b00;
  localparam logic [1:0]  OP_MULH   = 2'b01;
  localparam logic [1:0]  OP_MULSAT = 2'b10;
  localparam logic [1:0]  OP_RSVD   = 2'b11;
  localparam logic [31:0] SAT_MAX   = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t             state_reg;
  logic [1:0]         op_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic               ready_reg;
  logic               start_reg;
  logic               valid_reg;
  logic               ovf_reg;
  logic               err_reg;
  logic [31:0]        a_reg;
  logic [31:0]        b_reg;
  logic [31:0]        result_reg;
  logic [TAG_W-1:0]   out_tag_reg;

  // The product fits in 32 bits only when bits 63..32 all copy bit 31.
  logic [31:0] sign_split;
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_ovf
      assign sign_split[gi] = mul_product[32+gi] ^ mul_product[31];
    end
  endgenerate

  logic        prod_ovf;
  logic        in_zero;
  logic [31:0] sat_value;
  logic [31:0] result_next;

  assign prod_ovf = |sign_split;
  assign in_zero  = (in_a == 32'd0) || (in_b == 32'd0);

  always_comb begin
    sat_value = mul_product[31:0];
    if (prod_ovf) begin
      sat_value = mul_product[63] ? SAT_MIN : SAT_MAX;
    end
    result_next = mul_product[31:0];
    case (op_reg)
      OP_MUL:    result_next = mul_product[31:0];
      OP_MULH:   result_next = mul_product[63:32];
      OP_MULSAT: result_next = sat_value;
      default:   result_next = mul_product[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      op_reg      <= OP_MUL;
      tag_reg     <= '0;
      ready_reg   <= 1'b1;
      start_reg   <= 1'b0;
      valid_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      err_reg     <= 1'b0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      result_reg  <= 32'd0;
      out_tag_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            op_reg  <= in_op;
            tag_reg <= in_tag;
            if (in_op == OP_RSVD) begin
              result_reg  <= 32'd0;
              ovf_reg     <= 1'b0;
              err_reg     <= 1'b1;
              out_tag_reg <= in_tag;
              valid_reg   <= 1'b1;
              ready_reg   <= 1'b0;
              state_reg   <= S_HOLD;
            end else if (in_zero) begin
              // A zero operand needs no multiplier round trip.
              result_reg  <= 32'd0;
              ovf_reg     <= 1'b0;
              err_reg     <= 1'b0;
              out_tag_reg <= in_tag;
              valid_reg   <= 1'b1;
              ready_reg   <= 1'b0;
              state_reg   <= S_HOLD;
            end else begin
              a_reg     <= in_a;
              b_reg     <= in_b;
              start_reg <= 1'b1;
              ready_reg <= 1'b0;
              state_reg <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          // done may still be high from the previous op; the multiplier
          // clears it on this edge, so it is not looked at here.
          start_reg <= 1'b0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            result_reg  <= result_next;
            ovf_reg     <= prod_ovf;
            err_reg     <= 1'b0;
            out_tag_reg <= tag_reg;
            valid_reg   <= 1'b1;
            state_reg   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          start_reg <= 1'b0;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = ready_reg;
  assign mul_start  = start_reg;
  assign mul_a      = a_reg;
  assign mul_b      = b_reg;
  assign out_valid  = valid_reg;
  assign out_result = result_reg;
  assign out_ovf    = ovf_reg;
  assign out_err    = err_reg;
  assign out_tag    = out_tag_reg;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl with a behavioural 34-cycle multiplier and a
// queue of expected results checked as the DUT hands them over.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [3:0]  in_tag = 4'd0;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_product;
  logic        mul_done;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_err;
  logic [3:0]  out_tag;

  mul_issue_ctrl #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .out_err(out_err), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: done first visible 34 cycles after the start cycle,
  // and stays high until the next start. Product is junk unless done.
  logic [31:0] m_a, m_b;
  logic [63:0] m_prod;
  logic        m_busy;
  logic        m_done;
  int          m_cnt;
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_prod <= 64'd0;
      m_a <= 32'd0; m_b <= 32'd0;
    end else if (mul_start) begin
      m_busy <= 1'b1; m_done <= 1'b0; m_cnt <= 0; m_a <= mul_a; m_b <= mul_b;
    end else if (m_busy) begin
      if (m_cnt == 32) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_prod <= 64'(longint'($signed(m_a)) * longint'($signed(m_b)));
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end
  assign mul_done    = m_done;
  assign mul_product = m_done ? m_prod : 64'hDEAD_BEEF_0BAD_F00D;

  typedef struct {
    logic [31:0] result;
    logic        ovf;
    logic        err;
    logic [3:0]  tag;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_log[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  int   last_start_cyc = -1;
  logic [31:0] start_a = 32'd0;
  logic [31:0] start_b = 32'd0;

  // Monitor: logs accepts and starts, compares every valid cycle against the
  // head of the queue, pops on handshake.
  initial begin
    logic prev_valid;
    int   lat;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          acc_q.push_back(cyc);
          acc_log.push_back(cyc);
        end
        if (mul_start) begin
          start_cnt++;
          last_start_cyc = cyc;
          start_a = mul_a;
          start_b = mul_b;
        end
        if (out_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result cyc=%0d got result=%h tag=%0d, required no output", cyc, out_result, out_tag);
          end else begin
            if ({out_result, out_ovf, out_err, out_tag} !==
                {exp_q[0].result, exp_q[0].ovf, exp_q[0].err, exp_q[0].tag}) begin
              errors++;
              $display("FAIL result cyc=%0d got res=%h ovf=%b err=%b tag=%0d, required res=%h ovf=%b err=%b tag=%0d",
                       cyc, out_result, out_ovf, out_err, out_tag,
                       exp_q[0].result, exp_q[0].ovf, exp_q[0].err, exp_q[0].tag);
            end
            if (!prev_valid) begin
              checks++;
              lat = (acc_q.size() > 0) ? cyc - acc_q[0] : -1;
              if (lat !== exp_q[0].lat) begin
                errors++;
                $display("FAIL latency cyc=%0d got %0d, required %0d", cyc, lat, exp_q[0].lat);
              end
            end
            if (out_ready) begin
              $display("result res=%h ovf=%b err=%b tag=%0d at cyc %0d", out_result, out_ovf, out_err, out_tag, cyc);
              void'(exp_q.pop_front());
              if (acc_q.size() > 0) void'(acc_q.pop_front());
            end
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o, output logic e, output int lat);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = 32'd0; o = 1'b0; e = 1'b0; lat = 36;
    if (op == 2'b11) begin
      e = 1'b1; lat = 1;
    end else if (a == 32'd0 || b == 32'd0) begin
      lat = 1;
    end else begin
      o = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      case (op)
        2'b00: r = p[31:0];
        2'b01: r = p[63:32];
        default: r = !o ? p[31:0] : (p > 0 ? 32'h7FFF_FFFF : 32'h8000_0000);
      endcase
    end
  endfunction

  // Starts and ends at posedge+1; returns once the request was accepted.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] r, input logic o,
                      input logic e, input int lat);
    int n;
    exp_q.push_back('{result: r, ovf: o, err: e, tag: tag, lat: lat});
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready=0 for 200 cycles, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending results, required 0", exp_q.size());
      exp_q.delete(); acc_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, mul_start, mul_a, mul_b, out_valid, out_result, out_ovf, out_err, out_tag} !==
        {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b st=%b a=%h b=%h v=%b res=%h ovf=%b err=%b tag=%0d, required 1 0 0 0 0 0 0 0 0",
               in_ready, mul_start, mul_a, mul_b, out_valid, out_result, out_ovf, out_err, out_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int sc0;
    sc0 = start_cnt;
    send(2'b00, 32'd7, 32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFEB, 1'b0, 1'b0, 36);
    drain();
    checks++;
    if (start_cnt - sc0 !== 1 || last_start_cyc !== acc_log[acc_log.size()-1] + 1) begin
      errors++;
      $display("FAIL mul_start_pulse got count=%0d at cyc %0d, required 1 at cyc %0d",
               start_cnt - sc0, last_start_cyc, acc_log[acc_log.size()-1] + 1);
    end
    checks++;
    if (start_a !== 32'd7 || start_b !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL mul_operands got a=%h b=%h, required a=00000007 b=fffffffd", start_a, start_b);
    end
  endtask

  task automatic test_mulh();
    send(2'b01, 32'h4000_0000, 32'd4, 4'd1, 32'h0000_0001, 1'b1, 1'b0, 36);
    send(2'b00, 32'h4000_0000, 32'd4, 4'd2, 32'h0000_0000, 1'b1, 1'b0, 36);
    drain();
  endtask

  task automatic test_mulsat();
    send(2'b10, 32'h7FFF_FFFF, 32'd2, 4'd3, 32'h7FFF_FFFF, 1'b1, 1'b0, 36);
    send(2'b10, 32'hC000_0000, 32'd4, 4'd4, 32'h8000_0000, 1'b1, 1'b0, 36);
    send(2'b10, 32'd1000, 32'hFFFF_FC18, 4'd6, 32'hFFF0_BDC0, 1'b0, 1'b0, 36);
    drain();
  endtask

  task automatic test_fast_reserved();
    int sc0;
    sc0 = start_cnt;
    send(2'b00, 32'd0, 32'h1234, 4'd7, 32'd0, 1'b0, 1'b0, 1);
    send(2'b11, 32'd5, 32'd6, 4'd8, 32'd0, 1'b0, 1'b1, 1);
    send(2'b01, 32'h1234, 32'd0, 4'd9, 32'd0, 1'b0, 1'b0, 1);
    drain();
    checks++;
    if (start_cnt !== sc0) begin
      errors++;
      $display("FAIL fast_no_start got %0d starts, required 0", start_cnt - sc0);
    end
  endtask

  task automatic test_backpressure();
    int sc0, n, bad;
    out_ready = 1'b0;
    send(2'b00, 32'd11, 32'd13, 4'd10, 32'd143, 1'b0, 1'b0, 36);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL bp_valid_timeout got out_valid=0, required 1");
    end
    @(posedge clk); #1;
    // Second request waits while the first result is held.
    exp_q.push_back('{result: 32'hFFFF_FF9C, ovf: 1'b0, err: 1'b0, tag: 4'd11, lat: 36});
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'hFFFF_FFF6; in_b = 32'd10; in_tag = 4'd11;
    sc0 = start_cnt;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || start_cnt != sc0) begin
      errors++;
      $display("FAIL bp_hold got %0d bad cycles and %0d starts, required 0 and 0", bad, start_cnt - sc0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_op();
    int bad;
    send(2'b00, 32'd7, 32'd9, 4'd12, 32'd63, 1'b0, 1'b0, 36);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete(); acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, mul_start, mul_a, mul_b, out_valid, out_result, out_ovf, out_err, out_tag} !==
        {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL midop_reset got rdy=%b st=%b a=%h b=%h v=%b res=%h tag=%0d, required reset values",
               in_ready, mul_start, mul_a, mul_b, out_valid, out_result, out_tag);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || mul_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midop_stale got %0d active cycles, required 0", bad);
    end
    @(posedge clk); #1;
    send(2'b00, 32'd5, 32'd6, 4'd13, 32'd30, 1'b0, 1'b0, 36);
    drain();
  endtask

  task automatic test_back_to_back();
    int base;
    logic [1:0]  op;
    logic [31:0] a, b, r;
    logic        o, e;
    int          lat;
    base = acc_log.size();
    for (int i = 0; i < 4; i++) begin
      op = 2'($urandom_range(0, 2));
      a = $urandom(); if (a == 32'd0) a = 32'd1;
      b = (i[0]) ? 32'($urandom_range(1, 100000)) : $urandom();
      if (b == 32'd0) b = 32'd3;
      model(op, a, b, r, o, e, lat);
      send(op, a, b, 4'(i), r, o, e, lat);
    end
    drain();
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (acc_log[base+k] - acc_log[base+k-1] !== 37) begin
        errors++;
        $display("FAIL throughput got accept spacing %0d, required 37", acc_log[base+k] - acc_log[base+k-1]);
      end
    end
    base = acc_log.size();
    send(2'b11, 32'd1, 32'd1, 4'd14, 32'd0, 1'b0, 1'b1, 1);
    send(2'b10, 32'd0, 32'd1, 4'd15, 32'd0, 1'b0, 1'b0, 1);
    drain();
    checks++;
    if (acc_log[base+1] - acc_log[base] !== 2) begin
      errors++;
      $display("FAIL fast_throughput got accept spacing %0d, required 2", acc_log[base+1] - acc_log[base]);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_mul();
    test_mulh();
    test_mulsat();
    test_fast_reserved();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
